// File: rtl/vdc_pkg.sv
// Shared types for the VDC RAM slot scheduler.
// slot_t names the owner of one character-column RAM slot.
package vdc_pkg;

   typedef enum logic [2:0] {
      SL_IDLE = 3'd0,
      SL_CHAR = 3'd1,
      SL_SCRN = 3'd2,
      SL_ATTR = 3'd3,
      SL_CPU  = 3'd4,
      SL_RFSH = 3'd5
   } slot_t;

   // Columns at each end of the line reserved for internal housekeeping
   localparam int INT_COLS = 2;

endpackage

// File: rtl/vdc_fetch_ctr.sv
// Row-prefetch index counter: clears at row start, steps once per completed fetch,
// and reports whether the index (as seen after a same-cycle clear) is below a limit.
module vdc_fetch_ctr #(
   parameter int IDX_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic [7:0]       limit,
   output logic [IDX_W-1:0] idx,
   output logic             avail
);

   localparam int CW = (IDX_W > 8) ? IDX_W : 8;

   logic [IDX_W-1:0] idx_p0;

   // Arbitration in a restart column must see the cleared index
   always_comb begin
      idx_p0 = clear ? '0 : idx;
      avail  = CW'(idx_p0) < CW'(limit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (inc && (idx != '1)) begin
         idx <= idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/vdc_slot_arbiter.sv
// Per-column RAM slot scheduler: one owner per slot among character fetch, refresh,
// screen/attribute row prefetch and CPU access, plus refresh address and CPU handshake.
module vdc_slot_arbiter
   import vdc_pkg::*;
#(
   parameter int S_LATCH_WIDTH = 80,
   parameter int RFSH_BITS     = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             hold,
   input  logic                             newCol,
   input  logic                             endCol,
   input  logic [7:0]                       col,
   input  logic [7:0]                       reg_ht,
   input  logic [7:0]                       reg_hd,
   input  logic [3:0]                       reg_drr,
   input  logic                             reg_atr,
   input  logic                             fetchRow,
   input  logic                             fetchFrame,
   input  logic                             lastRow,
   input  logic                             char_req,
   input  logic                             cpu_req,
   output logic                             cpu_ack,
   output slot_t                            grant,
   output logic                             slot_done,
   output slot_t                            done_kind,
   output logic [$clog2(S_LATCH_WIDTH)-1:0] scrn_idx,
   output logic [$clog2(S_LATCH_WIDTH)-1:0] attr_idx,
   output logic [RFSH_BITS-1:0]             rfsh_addr
);

   localparam int IDX_W = $clog2(S_LATCH_WIDTH);

   logic       col_open;
   logic       col_close;
   logic       close_ok;
   logic       restart;
   logic       slot_open;
   logic [8:0] col9;
   logic [8:0] ht9;
   logic [8:0] hd9;
   logic [8:0] rf_end9;
   logic       int_win;
   logic       rf_win;
   logic [7:0] attr_limit;
   logic       scrn_avail;
   logic       attr_avail;
   logic       scrn_inc;
   logic       attr_inc;
   slot_t      grant_p0;

   // Stage 0: strobe qualification, windows and arbitration
   // A simultaneous open/close is illegal; the close wins and the open is dropped.
   assign col_open  = enable && newCol && !endCol;
   assign col_close = enable && endCol;
   assign close_ok  = col_close && slot_open && !hold;
   assign restart   = col_open && !hold && (col == 8'd0) && (fetchRow || fetchFrame);

   assign col9    = {1'b0, col};
   assign ht9     = {1'b0, reg_ht};
   assign hd9     = {1'b0, reg_hd};
   assign rf_end9 = hd9 + {5'd0, reg_drr};

   assign int_win = (ht9 < 9'(INT_COLS)) || (col9 < 9'(INT_COLS)) ||
                    (col9 >= ht9 - 9'(INT_COLS));
   assign rf_win  = (col9 >= hd9) && (col9 < rf_end9);

   assign attr_limit = lastRow ? 8'd2 : reg_hd;
   assign scrn_inc   = close_ok && (grant == SL_SCRN);
   assign attr_inc   = close_ok && (grant == SL_ATTR);

   vdc_fetch_ctr #(.IDX_W(IDX_W)) u_scrn_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (restart),
      .inc   (scrn_inc),
      .limit (reg_hd),
      .idx   (scrn_idx),
      .avail (scrn_avail)
   );

   vdc_fetch_ctr #(.IDX_W(IDX_W)) u_attr_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (restart && reg_atr),
      .inc   (attr_inc),
      .limit (attr_limit),
      .idx   (attr_idx),
      .avail (attr_avail)
   );

   always_comb begin
      grant_p0 = SL_IDLE;
      if (hold) begin
         grant_p0 = SL_IDLE;
      end else if (char_req) begin
         grant_p0 = SL_CHAR;
      end else if (!int_win && rf_win) begin
         grant_p0 = SL_RFSH;
      end else if (!int_win && scrn_avail) begin
         grant_p0 = SL_SCRN;
      end else if (!int_win && reg_atr && attr_avail) begin
         grant_p0 = SL_ATTR;
      end else if (cpu_req) begin
         grant_p0 = SL_CPU;
      end
   end

   // Stage 1: registered grant, close strobes and refresh address
   // slot_open gates the close report so a slot abandoned by reset never completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant     <= SL_IDLE;
         done_kind <= SL_IDLE;
         slot_done <= 1'b0;
         cpu_ack   <= 1'b0;
         rfsh_addr <= '0;
         slot_open <= 1'b0;
      end else begin
         slot_done <= 1'b0;
         cpu_ack   <= 1'b0;
         if (col_close) begin
            slot_open <= 1'b0;
            if (slot_open) begin
               slot_done <= 1'b1;
               done_kind <= grant;
               cpu_ack   <= (grant == SL_CPU) && !hold;
            end
         end else if (col_open) begin
            grant     <= grant_p0;
            slot_open <= 1'b1;
            if (grant_p0 == SL_RFSH) begin
               rfsh_addr <= rfsh_addr + RFSH_BITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vdc_slot_arbiter.sv
// Scoreboard bench for vdc_slot_arbiter: a column-level model queues expected grants
// and close reports, which are popped and compared when the DUT presents them.
module tb_vdc_slot_arbiter;
   import vdc_pkg::*;

   localparam int SLW = 80;
   localparam int RB  = 8;
   localparam int IW  = $clog2(SLW);

   logic          clk = 1'b0;
   logic          reset, enable, hold, newCol, endCol;
   logic [7:0]    col, reg_ht, reg_hd;
   logic [3:0]    reg_drr;
   logic          reg_atr, fetchRow, fetchFrame, lastRow, char_req, cpu_req;
   logic          cpu_ack, slot_done;
   slot_t         grant, done_kind;
   logic [IW-1:0] scrn_idx, attr_idx;
   logic [RB-1:0] rfsh_addr;

   always #5 clk = ~clk;

   vdc_slot_arbiter #(.S_LATCH_WIDTH(SLW), .RFSH_BITS(RB)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .hold       (hold),
      .newCol     (newCol),
      .endCol     (endCol),
      .col        (col),
      .reg_ht     (reg_ht),
      .reg_hd     (reg_hd),
      .reg_drr    (reg_drr),
      .reg_atr    (reg_atr),
      .fetchRow   (fetchRow),
      .fetchFrame (fetchFrame),
      .lastRow    (lastRow),
      .char_req   (char_req),
      .cpu_req    (cpu_req),
      .cpu_ack    (cpu_ack),
      .grant      (grant),
      .slot_done  (slot_done),
      .done_kind  (done_kind),
      .scrn_idx   (scrn_idx),
      .attr_idx   (attr_idx),
      .rfsh_addr  (rfsh_addr)
   );

   typedef struct {
      slot_t kind;
      logic  ack;
   } done_t;

   int    checks = 0;
   int    errors = 0;
   int    m_scrn, m_attr, m_rfsh;
   slot_t m_grant;
   bit    m_open;
   slot_t q_grant[$];
   done_t q_done[$];
   int    n_kind[6];
   int    n_ack, first_scrn, last_scrn;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      if (obs !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
      end
   endtask

   task automatic clr_tally();
      for (int k = 0; k < 6; k++) n_kind[k] = 0;
      n_ack      = 0;
      first_scrn = -1;
      last_scrn  = -1;
   endtask

   task automatic model_reset();
      m_scrn  = 0;
      m_attr  = 0;
      m_rfsh  = 0;
      m_grant = SL_IDLE;
      m_open  = 1'b0;
   endtask

   task automatic open_col(input int c, input bit fr, input bit chr, input bit cpu);
      slot_t g;
      bit    iw, rw;
      int    ht, hd, lim;
      @(negedge clk);
      col      = 8'(c);
      fetchRow = fr;
      char_req = chr;
      cpu_req  = cpu;
      enable   = 1'b1;
      newCol   = 1'b1;
      ht  = int'(reg_ht);
      hd  = int'(reg_hd);
      iw  = (ht < 2) || (c < 2) || (c >= ht - 2);
      rw  = (c >= hd) && (c < hd + int'(reg_drr));
      if (!hold && c == 0 && (fr || fetchFrame)) begin
         m_scrn = 0;
         if (reg_atr) m_attr = 0;
      end
      lim = lastRow ? 2 : hd;
      if (hold)                                g = SL_IDLE;
      else if (chr)                            g = SL_CHAR;
      else if (!iw && rw)                      g = SL_RFSH;
      else if (!iw && m_scrn < hd)             g = SL_SCRN;
      else if (!iw && reg_atr && m_attr < lim) g = SL_ATTR;
      else if (cpu)                            g = SL_CPU;
      else                                     g = SL_IDLE;
      if (g == SL_RFSH) m_rfsh = (m_rfsh + 1) % (1 << RB);
      m_grant = g;
      m_open  = 1'b1;
      q_grant.push_back(g);
      @(posedge clk);
      #1;
      newCol   = 1'b0;
      fetchRow = 1'b0;
      @(negedge clk);
      g = q_grant.pop_front();
      check("grant", grant, g);
      check("rfsh_addr", rfsh_addr, m_rfsh);
      check("scrn_idx_open", scrn_idx, m_scrn);
      check("attr_idx_open", attr_idx, m_attr);
      check("open_no_done", slot_done, 0);
      check("open_no_ack", cpu_ack, 0);
      if (int'(grant) < 6) n_kind[int'(grant)]++;
      if (grant == SL_SCRN) begin
         if (first_scrn < 0) first_scrn = c;
         last_scrn = c;
      end
   endtask

   task automatic close_col();
      done_t d;
      bit    expect_done;
      @(negedge clk);
      enable = 1'b1;
      endCol = 1'b1;
      expect_done = m_open;
      if (m_open) begin
         d.kind = m_grant;
         d.ack  = (m_grant == SL_CPU) && !hold;
         q_done.push_back(d);
         if (!hold && m_grant == SL_SCRN) m_scrn++;
         if (!hold && m_grant == SL_ATTR) m_attr++;
      end
      m_open = 1'b0;
      @(posedge clk);
      #1;
      endCol = 1'b0;
      @(negedge clk);
      if (expect_done) begin
         d = q_done.pop_front();
         check("slot_done", slot_done, 1);
         check("done_kind", done_kind, d.kind);
         check("cpu_ack", cpu_ack, d.ack);
      end else begin
         check("stray_done", slot_done, 0);
         check("stray_ack", cpu_ack, 0);
      end
      if (cpu_ack) n_ack++;
      check("grant_kept", grant, m_grant);
      check("scrn_idx_close", scrn_idx, m_scrn);
      check("attr_idx_close", attr_idx, m_attr);
      @(negedge clk);
      check("done_pulse", slot_done, 0);
      check("ack_pulse", cpu_ack, 0);
   endtask

   task automatic run_line(input bit fr, input int char_below, input bit cpu);
      for (int c = 0; c < int'(reg_ht); c++) begin
         open_col(c, fr && (c == 0), c < char_below, cpu);
         close_col();
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_grant"}, grant, SL_IDLE);
      check({tag, "_done_kind"}, done_kind, SL_IDLE);
      check({tag, "_slot_done"}, slot_done, 0);
      check({tag, "_cpu_ack"}, cpu_ack, 0);
      check({tag, "_scrn_idx"}, scrn_idx, 0);
      check({tag, "_attr_idx"}, attr_idx, 0);
      check({tag, "_rfsh_addr"}, rfsh_addr, 0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; hold = 1'b0; newCol = 1'b0; endCol = 1'b0;
      col = 8'd0; reg_ht = 8'd99; reg_hd = 8'd80; reg_drr = 4'd5; reg_atr = 1'b1;
      fetchRow = 1'b0; fetchFrame = 1'b0; lastRow = 1'b0; char_req = 1'b0; cpu_req = 1'b0;
      model_reset();
      clr_tally();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      // Display line: characters fill the displayed columns, then refresh and screen prefetch
      clr_tally();
      run_line(1'b1, 80, 1'b0);
      check("t1_rfsh_count", n_kind[SL_RFSH], 5);
      check("t1_rfsh_addr", rfsh_addr, 5);
      check("t1_scrn_count", n_kind[SL_SCRN], 12);
      check("t1_scrn_first", first_scrn, 85);
      check("t1_scrn_last", last_scrn, 96);

      // CPU held with nothing left to prefetch: every column, including the window, goes to CPU
      reg_hd = 8'd12; reg_atr = 1'b0; reg_drr = 4'd0;
      clr_tally();
      run_line(1'b0, 0, 1'b1);
      check("t2_cpu_count", n_kind[SL_CPU], 99);
      check("t2_ack_count", n_ack, 99);

      // Character fetch outranks a pending CPU request
      clr_tally();
      open_col(10, 1'b0, 1'b1, 1'b1);
      close_col();
      open_col(11, 1'b0, 1'b0, 1'b1);
      close_col();
      check("t3_char_count", n_kind[SL_CHAR], 1);
      check("t3_cpu_count", n_kind[SL_CPU], 1);
      check("t3_ack_count", n_ack, 1);
      cpu_req = 1'b0;

      // Last row: attribute prefetch is limited to two slots
      reg_hd = 8'd80; reg_atr = 1'b1; lastRow = 1'b1;
      clr_tally();
      run_line(1'b1, 0, 1'b0);
      check("t4_attr_count", n_kind[SL_ATTR], 2);
      check("t4_attr_idx", attr_idx, 2);
      check("t4_scrn_count", n_kind[SL_SCRN], 80);
      check("t4_scrn_idx", scrn_idx, 80);

      // Hold arrives inside an open CPU slot, then spans a whole line
      clr_tally();
      open_col(50, 1'b0, 1'b0, 1'b1);
      hold = 1'b1;
      close_col();
      check("t5_held_cpu_ack", n_ack, 0);
      clr_tally();
      run_line(1'b1, 99, 1'b1);
      check("t5_idle_count", n_kind[SL_IDLE], 99);
      check("t5_hold_acks", n_ack, 0);
      check("t5_scrn_frozen", scrn_idx, 80);
      check("t5_attr_frozen", attr_idx, 2);
      hold = 1'b0;
      clr_tally();
      open_col(5, 1'b0, 1'b0, 1'b1);
      close_col();
      check("t5_release_ack", n_ack, 1);

      // Illegal simultaneous open/close: the close is reported, the open is dropped
      open_col(30, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      col = 8'd31; newCol = 1'b1; endCol = 1'b1;
      @(posedge clk);
      #1 newCol = 1'b0; endCol = 1'b0;
      @(negedge clk);
      check("t7_done", slot_done, 1);
      check("t7_kind", done_kind, SL_CPU);
      check("t7_ack", cpu_ack, 1);
      check("t7_grant_kept", grant, SL_CPU);
      m_open = 1'b0;
      close_col();

      // Reset between open and close abandons the CPU slot
      open_col(20, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      cpu_req = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_state("t6");
      close_col();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
